// File: rtl/cmos_pixel_pack.sv
// cmos_pixel_pack: OV7670 byte stream -> packed 32-bit DDR write words.
// Turns RGB565 byte pairs into pixels and packs two pixels per word. Sensor settling frames are
// dropped, and each captured frame ends with a frame_switch pulse for the DDR FIFO controller.
// Optional feature: define CAPTURE_GRAY_EN to replace each pixel by its luma (RGB565 gray).
// This adds one pipeline stage.

module cmos_pixel_pack #(
   parameter int unsigned H_PIXELS    = 640,
   parameter int unsigned V_LINES     = 480,
   parameter int unsigned SKIP_FRAMES = 10
) (
   input  logic        camera_pclk,
   input  logic        reset,
   input  logic        init_done,
   input  logic        camera_vsync,
   input  logic        camera_href,
   input  logic [7:0]  camera_data,
   output logic        ddr_wren,
   output logic [31:0] ddr_data_camera,
   output logic        data_valid_wr,
   output logic        frame_switch,
   output logic        frame_err,
   output logic [15:0] frame_cnt
);

   localparam int unsigned FrameWords = H_PIXELS * V_LINES / 2;

   typedef enum logic [1:0] {StIdle, StSkip, StWaitVs, StActive} state_e;

   state_e      state_q, state_d;
   logic        init_done_q, vsync_q, vsync_prev_q, href_q;
   logic [7:0]  data_q;
   logic [31:0] skip_cnt_q;
   logic [1:0]  byte_cnt_q;
   logic [15:0] pix0_q;
   logic [7:0]  pix1_hi_q;
   logic [31:0] word_q;
   logic        word_vld_q;
   logic [31:0] word_cnt_q;
   logic        frame_switch_q, frame_err_q;
   logic [15:0] frame_cnt_q;
   logic        vs_rise, vs_fall, in_frame, frame_end, cap_en, frame_done;

   assign vs_rise = vsync_q & ~vsync_prev_q;
   assign vs_fall = ~vsync_q & vsync_prev_q;

   // Single input register stage; vsync_prev_q gives edge detection on the registered vsync.
   always_ff @(posedge camera_pclk) begin
      if (reset) begin
         init_done_q  <= 1'b0;
         vsync_q      <= 1'b0;
         vsync_prev_q <= 1'b0;
         href_q       <= 1'b0;
         data_q       <= 8'd0;
      end else begin
         init_done_q  <= init_done;
         vsync_q      <= camera_vsync;
         vsync_prev_q <= vsync_q;
         href_q       <= camera_href;
         data_q       <= camera_data;
      end
   end

   // FSM state register.
   always_ff @(posedge camera_pclk) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // FSM next state; losing init_done aborts from any state.
   always_comb begin
      state_d = state_q;
      if (!init_done_q) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:   state_d = StSkip;
            StSkip: begin
               if (SKIP_FRAMES == 0) begin
                  state_d = StWaitVs;
               end else if (vs_rise && (skip_cnt_q == SKIP_FRAMES - 1)) begin
                  state_d = StWaitVs;
               end
            end
            StWaitVs: if (vs_fall) state_d = StActive;
            StActive: if (vs_rise) state_d = StWaitVs;
            default:  state_d = StIdle;
         endcase
      end
   end

   // FSM outputs; a vsync rise closes the frame and discards any partial word on that cycle.
   always_comb begin
      in_frame      = (state_q == StActive) && init_done_q;
      data_valid_wr = in_frame;
      frame_end     = in_frame && vs_rise;
      cap_en        = in_frame && !vs_rise && href_q;
   end

   // Count settling frames (vsync rises) while in SKIP; cleared elsewhere.
   always_ff @(posedge camera_pclk) begin
      if (reset || (state_q != StSkip)) begin
         skip_cnt_q <= 32'd0;
      end else if (vs_rise) begin
         skip_cnt_q <= skip_cnt_q + 32'd1;
      end
   end

   // Byte assembly: b=0/1 pixel0 hi/lo, b=2/3 pixel1 hi/lo; a gap in href drops a partial word.
   always_ff @(posedge camera_pclk) begin
      if (reset) begin
         byte_cnt_q <= 2'd0;
         pix0_q     <= 16'd0;
         pix1_hi_q  <= 8'd0;
         word_q     <= 32'd0;
         word_vld_q <= 1'b0;
      end else begin
         word_vld_q <= 1'b0;
         if (cap_en) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            unique case (byte_cnt_q)
               2'd0: pix0_q[15:8] <= data_q;
               2'd1: pix0_q[7:0]  <= data_q;
               2'd2: pix1_hi_q    <= data_q;
               2'd3: begin
                  word_q     <= {pix0_q, pix1_hi_q, data_q};
                  word_vld_q <= 1'b1;
               end
            endcase
         end else begin
            byte_cnt_q <= 2'd0;
         end
      end
   end

   // Words completed in the current frame; cleared when the frame starts.
   always_ff @(posedge camera_pclk) begin
      if (reset || ((state_q == StWaitVs) && vs_fall)) begin
         word_cnt_q <= 32'd0;
      end else if (cap_en && (byte_cnt_q == 2'd3)) begin
         word_cnt_q <= word_cnt_q + 32'd1;
      end
   end

`ifdef CAPTURE_GRAY_EN
   logic [31:0] gray_word_q;
   logic        gray_vld_q;
   logic        fs_pend_q;

   function automatic logic [15:0] to_gray(input logic [15:0] p);
      logic [7:0]  r, g, b;
      logic [15:0] y;
      r = {p[15:11], p[15:13]};
      g = {p[10:5], p[10:9]};
      b = {p[4:0], p[4:2]};
      y = 16'd77 * {8'd0, r} + 16'd150 * {8'd0, g} + 16'd29 * {8'd0, b};
      // y[15:8] is the 8-bit luma.
      return {y[15:11], y[15:10], y[15:11]};
   endfunction

   // Luma stage; a word still in flight when init_done drops is discarded.
   always_ff @(posedge camera_pclk) begin
      if (reset) begin
         gray_word_q <= 32'd0;
         gray_vld_q  <= 1'b0;
         fs_pend_q   <= 1'b0;
      end else begin
         gray_vld_q <= word_vld_q && init_done_q;
         fs_pend_q  <= frame_end;
         if (word_vld_q && init_done_q) begin
            gray_word_q <= {to_gray(word_q[31:16]), to_gray(word_q[15:0])};
         end
      end
   end

   assign ddr_wren        = gray_vld_q;
   assign ddr_data_camera = gray_word_q;
   // Delay the frame handshake so it follows the last word through the extra stage.
   assign frame_done      = fs_pend_q;
`else
   assign ddr_wren        = word_vld_q;
   assign ddr_data_camera = word_q;
   assign frame_done      = frame_end;
`endif

   // Frame handshake, frame counter and sticky word-count error.
   always_ff @(posedge camera_pclk) begin
      if (reset) begin
         frame_switch_q <= 1'b0;
         frame_cnt_q    <= 16'd0;
         frame_err_q    <= 1'b0;
      end else begin
         frame_switch_q <= frame_done;
         if (frame_done) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            if (word_cnt_q != FrameWords) frame_err_q <= 1'b1;
         end
      end
   end

   assign frame_switch = frame_switch_q;
   assign frame_err    = frame_err_q;
   assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_cmos_pixel_pack.sv
// Scoreboard bench for cmos_pixel_pack with a 4x2 frame and two skipped frames.
module tb_cmos_pixel_pack;

   localparam int unsigned H = 4;
   localparam int unsigned V = 2;
   localparam int unsigned SKIP = 2;
`ifdef CAPTURE_GRAY_EN
   localparam int LAT = 3;
   localparam logic [15:0] P0 = 16'hFFFF;
   localparam logic [15:0] P1 = 16'hF800;
   localparam logic [31:0] W1 = 32'hFFFF4A69;
   localparam logic [31:0] W2 = 32'h94B218E3;
   localparam logic [31:0] W3 = 32'h4A69FFFF;
   localparam logic [31:0] W4 = 32'h000094B2;
`else
   localparam int LAT = 2;
   localparam logic [15:0] P0 = 16'h1234;
   localparam logic [15:0] P1 = 16'h5678;
   localparam logic [31:0] W1 = 32'h12345678;
   localparam logic [31:0] W2 = 32'h07E0001F;
   localparam logic [31:0] W3 = 32'hF800FFFF;
   localparam logic [31:0] W4 = 32'h000007E0;
`endif

   logic        clk = 1'b0;
   logic        reset, init_done, vsync, href;
   logic [7:0]  data;
   logic        ddr_wren, data_valid_wr, frame_switch, frame_err;
   logic [31:0] ddr_data_camera;
   logic [15:0] frame_cnt;

   int          cmp_n = 0;
   int          err_n = 0;
   int          wren_n = 0;
   int          fs_n = 0;
   int          cyc_n = 0;
   int          first_wren_cyc = -1;
   int          t78 = 0;
   bit          track_first = 1'b0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n++;

   cmos_pixel_pack #(
      .H_PIXELS   (H),
      .V_LINES    (V),
      .SKIP_FRAMES(SKIP)
   ) dut (
      .camera_pclk    (clk),
      .reset          (reset),
      .init_done      (init_done),
      .camera_vsync   (vsync),
      .camera_href    (href),
      .camera_data    (data),
      .ddr_wren       (ddr_wren),
      .ddr_data_camera(ddr_data_camera),
      .data_valid_wr  (data_valid_wr),
      .frame_switch   (frame_switch),
      .frame_err      (frame_err),
      .frame_cnt      (frame_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_n++;
      if (act !== exp) begin
         err_n++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every strobe pops one expected word; strobes with nothing queued are errors.
   always @(negedge clk) begin
      if (ddr_wren) begin
         wren_n++;
         if (track_first) begin
            first_wren_cyc = cyc_n;
            track_first = 1'b0;
         end
         if (exp_q.size() == 0) begin
            cmp_n++;
            err_n++;
            $display("FAIL unexpected_wren: got word 0x%0h, expected no strobe", ddr_data_camera);
         end else begin
            check("ddr_data", ddr_data_camera, exp_q.pop_front());
         end
      end
      if (frame_switch) fs_n++;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] d);
      href = 1'b1;
      data = d;
      tick();
   endtask

   task automatic send_word(input logic [15:0] p0, input logic [15:0] p1,
                            input logic [31:0] e, input bit push);
      if (push) exp_q.push_back(e);
      send_byte(p0[15:8]);
      send_byte(p0[7:0]);
      send_byte(p1[15:8]);
      send_byte(p1[7:0]);
   endtask

   task automatic end_line();
      href = 1'b0;
      data = 8'h00;
      tick(3);
   endtask

   task automatic vs_pulse();
      vsync = 1'b1;
      tick(4);
      vsync = 1'b0;
      tick(4);
   endtask

   // Full 4-word frame; starts in ACTIVE, ends with vsync high.
   task automatic good_frame();
      send_word(16'h07E0, 16'h001F, W2, 1'b1);
      send_word(16'hF800, 16'hFFFF, W3, 1'b1);
      end_line();
      send_word(16'h0000, 16'h07E0, W4, 1'b1);
      send_word(P0, P1, W1, 1'b1);
      end_line();
      vsync = 1'b1;
      tick(4);
   endtask

   initial begin
      reset = 1'b1;
      init_done = 1'b0;
      vsync = 1'b0;
      href = 1'b0;
      data = 8'h00;
      tick(3);
      check("rst_wren", {31'd0, ddr_wren}, 32'd0);
      check("rst_data", ddr_data_camera, 32'd0);
      check("rst_valid", {31'd0, data_valid_wr}, 32'd0);
      check("rst_cnt", {16'd0, frame_cnt}, 32'd0);
      reset = 1'b0;
      init_done = 1'b1;
      tick(3);

      // Two settling frames, the first carrying data that must not be written.
      vs_pulse();
      send_word(16'hAAAA, 16'h5555, 32'd0, 1'b0);
      end_line();
      check("skip_valid", {31'd0, data_valid_wr}, 32'd0);
      check("skip_wren_n", wren_n, 0);
      vs_pulse();
      check("active_valid", {31'd0, data_valid_wr}, 32'd1);

      // First captured frame; first word also measures input-to-strobe latency.
      track_first = 1'b1;
      send_word(P0, P1, W1, 1'b1);
      t78 = cyc_n - 1;
      send_word(16'h07E0, 16'h001F, W2, 1'b1);
      end_line();
      send_word(16'hF800, 16'hFFFF, W3, 1'b1);
      send_word(16'h0000, 16'h07E0, W4, 1'b1);
      end_line();
      vsync = 1'b1;
      tick(4);
      check("latency", first_wren_cyc - t78, LAT);
      check("f1_wren_n", wren_n, 4);
      check("f1_fs_n", fs_n, 1);
      check("f1_cnt", {16'd0, frame_cnt}, 32'd1);
      check("f1_err", {31'd0, frame_err}, 32'd0);
      check("f1_valid", {31'd0, data_valid_wr}, 32'd0);
      vsync = 1'b0;
      tick(4);

      // Odd-length line: one word, trailing pixel dropped, frame flagged but still switched.
      send_word(16'h07E0, 16'h001F, W2, 1'b1);
      send_byte(8'hF8);
      send_byte(8'h00);
      end_line();
      vsync = 1'b1;
      tick(4);
      check("f2_wren_n", wren_n, 5);
      check("f2_err", {31'd0, frame_err}, 32'd1);
      check("f2_fs_n", fs_n, 2);
      check("f2_cnt", {16'd0, frame_cnt}, 32'd2);
      vsync = 1'b0;
      tick(4);

      // init_done dropped after two bytes: no word, capture stops, settling frames repeat.
      send_byte(8'h11);
      send_byte(8'h22);
      init_done = 1'b0;
      send_byte(8'h33);
      check("abort_valid", {31'd0, data_valid_wr}, 32'd0);
      send_byte(8'h44);
      end_line();
      tick(4);
      check("abort_wren_n", wren_n, 5);
      check("abort_fs_n", fs_n, 2);
      init_done = 1'b1;
      tick(3);
      vs_pulse();
      send_word(16'hF800, 16'hFFFF, 32'd0, 1'b0);
      end_line();
      check("reskip_wren_n", wren_n, 5);
      vs_pulse();
      good_frame();
      check("f4_wren_n", wren_n, 9);
      check("f4_fs_n", fs_n, 3);
      check("f4_cnt", {16'd0, frame_cnt}, 32'd3);
      check("f4_err_sticky", {31'd0, frame_err}, 32'd1);
      vsync = 1'b0;
      tick(4);

      // Reset mid-line clears every output on the next cycle.
      send_byte(8'h55);
      send_byte(8'h66);
      reset = 1'b1;
      href = 1'b0;
      tick();
      check("mrst_wren", {31'd0, ddr_wren}, 32'd0);
      check("mrst_data", ddr_data_camera, 32'd0);
      check("mrst_valid", {31'd0, data_valid_wr}, 32'd0);
      check("mrst_fs", {31'd0, frame_switch}, 32'd0);
      check("mrst_err", {31'd0, frame_err}, 32'd0);
      check("mrst_cnt", {16'd0, frame_cnt}, 32'd0);
      reset = 1'b0;
      tick(3);

      // Frame counter wrap: preload 0xFFFF, then one more captured frame.
      vs_pulse();
      vs_pulse();
      force dut.frame_cnt_q = 16'hFFFF;
      tick();
      release dut.frame_cnt_q;
      tick();
      check("wrap_pre", {16'd0, frame_cnt}, 32'h0000FFFF);
      good_frame();
      check("wrap_cnt", {16'd0, frame_cnt}, 32'd0);
      check("wrap_fs_n", fs_n, 4);
      check("wrap_err", {31'd0, frame_err}, 32'd0);
      check("wrap_wren_n", wren_n, 13);
      vsync = 1'b0;
      tick(4);
      check("queue_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
      $finish;
   end

endmodule
